mips32_trace_buffer: RTL and testbench
======================================

MIPS32_TRACE_BUFFER -- requirements
Module: mips32_trace_buffer

Interface
REQ-001 The block SHALL have one clock `clk` and an asynchronous active-low reset `rst_n`; all state SHALL be sampled on the rising edge of `clk`.
REQ-002 The parameters SHALL be, one per line (name, default, meaning):
- DEPTH, 16, number of trace entries; power of two, at least 4.
- PC_W, 32, width of the program counter.
- DATA_W, 32, width of the result.
- MODE_FILTER, 0, when 1 only register-writing retirements are captured.
- AW = log2(DEPTH), derived.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- cap_valid, in, 1, one instruction retired this cycle.
- cap_pc, in, PC_W, PC of the retired instruction.
- cap_instr, in, 32, instruction word.
- cap_result, in, DATA_W, ALU/writeback result.
- cap_regwrite, in, 1, the retirement writes the register file.
- cap_rd, in, 5, destination register.
- arm, in, 1, single-cycle pulse; start a trace.
- trig_opcode, in, 6, trigger opcode.
- trig_mask, in, 6, opcode compare mask; 1 = compare this bit.
- post_cnt, in, AW, number of entries captured after the trigger.
- out_valid, out, 1, readout entry available.
- out_ready, in, 1, consumer accepts the entry.
- out_pc, out_instr, out_result, out_rd, out_regwrite, out, widths as the matching cap_* ports, readout entry.
- state, out, 2, 0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- count, out, AW+1, number of valid entries.
- overflow, out, 1, pre-trigger history was overwritten.

Function
REQ-004 A capture SHALL be qualifying when cap_valid=1 and either MODE_FILTER=0 or cap_regwrite=1.
REQ-005 The trigger SHALL hit when a capture is qualifying and ((cap_instr[31:26] ^ trig_opcode) & trig_mask) == 0.
REQ-006 In IDLE, no entry SHALL be written; arm=1 SHALL go to ARMED, clearing wptr, count and overflow; a capture in the arm cycle SHALL NOT be recorded.
REQ-007 In ARMED, each qualifying capture SHALL write {pc, instr, result, rd, regwrite} at wptr and advance wptr modulo DEPTH.
REQ-008 count SHALL increment per write and saturate at DEPTH; a write while count==DEPTH SHALL set overflow, which is sticky until the next arm or reset.
REQ-009 The trigger entry SHALL itself be written. The next state SHALL be DONE if post_cnt==0, otherwise POST with remaining=post_cnt; the state change SHALL be visible one cycle after the trigger edge.
REQ-010 In POST, each qualifying capture SHALL be written per REQ-007/008 and decrement remaining; the write that brings remaining to 0 SHALL move the block to DONE. The trigger SHALL NOT be re-evaluated in POST.
REQ-011 arm=1 in ARMED SHALL restart the trace as in REQ-006; arm in POST or DONE SHALL be ignored.
REQ-012 In DONE, captures SHALL be ignored.
- rptr SHALL be (wptr - count) mod DEPTH on entry to DONE.
- out_valid SHALL equal (count != 0); out_* SHALL show the entry at rptr combinationally.
- Entries SHALL be read oldest first.
REQ-013 On out_valid && out_ready, rptr SHALL advance (with wrap) and count SHALL decrement; the pop that brings count to 0 SHALL return the block to IDLE.
REQ-014 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-015 out_valid SHALL be 0 in IDLE, ARMED and POST.

Reset
REQ-016 rst_n=0 SHALL immediately force the following, including mid-trace, with the partial trace discarded:
- state=IDLE.
- wptr, rptr, remaining and count = 0.
- overflow=0 and out_valid=0.
REQ-017 The trace RAM contents SHALL NOT be reset; out_pc, out_instr, out_result, out_rd and out_regwrite are don't-care while out_valid=0.

Verification (DEPTH=8)
REQ-018 Basic trigger:
- Stimulus: arm; captures at PC 0,4,8 (add); PC 12 beq (opcode 000100, mask 111111, post_cnt=2); PC 16,20.
- Response: DONE; count=6; readout PCs 0,4,8,12,16,20; then IDLE.
REQ-019 Wrap:
- Stimulus: 12 non-trigger captures at PC 0..44; trigger at PC 48; post_cnt=0.
- Response: count=8; overflow=1; readout PCs 20..48.
REQ-020 Backpressure:
- Stimulus: hold out_ready=0 for 3 cycles in DONE.
- Response: out_valid=1; out_pc stable; count unchanged.
REQ-021 trig_mask=000000: the first qualifying capture after arm triggers; with post_cnt=0, count=1.
REQ-022 Reset mid-trace: rst_n low during POST gives state=0, count=0, out_valid=0 without a clock edge.
REQ-023 MODE_FILTER=1:
- Stimulus: sw (regwrite=0) at PC 4 between addiu at PC 0 and PC 8.
- Response: readout PCs 0,8 only.

Source files
------------

// File: rtl/mips32_trace_buffer.sv
// Retirement trace buffer: records qualifying retirements into a circular RAM
// until an opcode trigger plus a post-trigger window, then drains the entries oldest first.
module mips32_trace_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MODE_FILTER = 0,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_valid,
  input  logic [PC_W-1:0]   cap_pc,
  input  logic [31:0]       cap_instr,
  input  logic [DATA_W-1:0] cap_result,
  input  logic              cap_regwrite,
  input  logic [4:0]        cap_rd,
  input  logic              arm,
  input  logic [5:0]        trig_opcode,
  input  logic [5:0]        trig_mask,
  input  logic [AW-1:0]     post_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd,
  output logic              out_regwrite,
  output logic [1:0]        state,
  output logic [AW:0]       count,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StPost = 2'd2, StDone = 2'd3} state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic [DATA_W-1:0] result;
    logic [4:0]        rd;
    logic              regwrite;
  } entry_t;

  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  state_e         state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW-1:0]  remaining_q, remaining_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           wr_en;
  logic           qual;
  logic           hit;
  entry_t         wr_entry;
  entry_t         rd_entry;
  entry_t         mem_q [DEPTH];

  assign qual = cap_valid && ((MODE_FILTER == 0) || cap_regwrite);
  assign hit  = qual && (((cap_instr[31:26] ^ trig_opcode) & trig_mask) == 6'd0);

  assign wr_entry = '{pc: cap_pc, instr: cap_instr, result: cap_result, rd: cap_rd,
                      regwrite: cap_regwrite};

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d    = StArmed;
          wptr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      StArmed: begin
        if (arm) begin
          wptr_d     = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (qual) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (count_q == CountFull) overflow_d = 1'b1;
          else                      count_d    = count_q + (AW + 1)'(1);
          if (hit) begin
            if (post_cnt == '0) begin
              state_d = StDone;
            end else begin
              state_d     = StPost;
              remaining_d = post_cnt;
            end
          end
        end
      end
      StPost: begin
        if (qual) begin
          wr_en       = 1'b1;
          wptr_d      = wptr_q + AW'(1);
          remaining_d = remaining_q - AW'(1);
          if (count_q == CountFull) overflow_d = 1'b1;
          else                      count_d    = count_q + (AW + 1)'(1);
          if (remaining_q == AW'(1)) state_d = StDone;
        end
      end
      StDone: begin
        if (out_valid && out_ready) begin
          rptr_d  = rptr_q + AW'(1);
          count_d = count_q - (AW + 1)'(1);
          if (count_q == (AW + 1)'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Oldest surviving entry sits count entries behind the write pointer; a full count wraps to 0.
    if (state_d == StDone && state_q != StDone) rptr_d = wptr_d - count_d[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Trace RAM is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_entry;
  end

  assign rd_entry     = mem_q[rptr_q];
  assign out_valid    = (state_q == StDone) && (count_q != '0);
  assign out_pc       = rd_entry.pc;
  assign out_instr    = rd_entry.instr;
  assign out_result   = rd_entry.result;
  assign out_rd       = rd_entry.rd;
  assign out_regwrite = rd_entry.regwrite;
  assign state        = state_q;
  assign count        = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_mips32_trace_buffer.sv
// Bench for mips32_trace_buffer (DEPTH=8): directed table and sequences plus random stimulus
// checked against a queue-based model of the trace semantics.
module tb_mips32_trace_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  localparam logic [31:0] ADD   = 32'h0000_0020;
  localparam logic [31:0] BEQ   = 32'h1000_0000;
  localparam logic [31:0] ADDIU = 32'h2400_0000;
  localparam logic [31:0] SW    = 32'hAC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_pc = '0;
  logic [31:0] cap_instr = '0;
  logic [31:0] cap_result = '0;
  logic        cap_regwrite = 1'b0;
  logic [4:0]  cap_rd = '0;
  logic        arm = 1'b0;
  logic [5:0]  trig_opcode = '0;
  logic [5:0]  trig_mask = '0;
  logic [AW-1:0] post_cnt = '0;
  logic        out_ready = 1'b0;

  logic        out_valid, out_regwrite, overflow;
  logic [31:0] out_pc, out_instr, out_result;
  logic [4:0]  out_rd;
  logic [1:0]  state;
  logic [AW:0] count;

  logic        f_out_valid, f_out_regwrite, f_overflow;
  logic [31:0] f_out_pc, f_out_instr, f_out_result;
  logic [4:0]  f_out_rd;
  logic [1:0]  f_state;
  logic [AW:0] f_count;

  always #5 clk = ~clk;

  mips32_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .MODE_FILTER(0)) dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_result(cap_result), .cap_regwrite(cap_regwrite), .cap_rd(cap_rd), .arm(arm),
    .trig_opcode(trig_opcode), .trig_mask(trig_mask), .post_cnt(post_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_result(out_result), .out_rd(out_rd), .out_regwrite(out_regwrite), .state(state),
    .count(count), .overflow(overflow)
  );

  mips32_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .MODE_FILTER(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_result(cap_result), .cap_regwrite(cap_regwrite), .cap_rd(cap_rd), .arm(arm),
    .trig_opcode(trig_opcode), .trig_mask(trig_mask), .post_cnt(post_cnt),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_pc(f_out_pc),
    .out_instr(f_out_instr), .out_result(f_out_result), .out_rd(f_out_rd),
    .out_regwrite(f_out_regwrite), .state(f_state), .count(f_count), .overflow(f_overflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
  } ent_t;

  typedef struct {
    bit          arm;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
    int          exp_state;
    int          exp_count;
  } vec_t;

  // Reference model for the unfiltered instance: the trace is just a bounded queue.
  ent_t mq[$];
  int   m_state;
  int   m_rem;
  bit   m_ovf;

  int n_vec;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_rem   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_push();
    ent_t e;
    e.pc = cap_pc; e.instr = cap_instr; e.result = cap_result; e.rd = cap_rd;
    e.rw = cap_regwrite;
    mq.push_back(e);
    if (mq.size() > DEPTH) begin
      mq.delete(0);
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_step();
    bit qual, hit;
    qual = cap_valid;
    hit  = qual && (((cap_instr[31:26] ^ trig_opcode) & trig_mask) == 6'd0);
    case (m_state)
      0: if (arm) begin m_state = 1; mq.delete(); m_ovf = 1'b0; end
      1: begin
        if (arm) begin
          mq.delete(); m_ovf = 1'b0;
        end else if (qual) begin
          model_push();
          if (hit) begin
            m_rem   = int'(post_cnt);
            m_state = (m_rem == 0) ? 3 : 2;
          end
        end
      end
      2: if (qual) begin
        model_push();
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
      default: if (out_ready && mq.size() > 0) begin
        mq.delete(0);
        if (mq.size() == 0) m_state = 0;
      end
    endcase
  endtask

  task automatic compare();
    bit mv;
    mv = (m_state == 3) && (mq.size() > 0);
    chk("state", state, m_state);
    chk("count", count, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
      chk("out_result", out_result, mq[0].result);
      chk("out_rd", out_rd, mq[0].rd);
      chk("out_regwrite", out_regwrite, mq[0].rw);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_cap(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                         input bit rw);
    cap_valid    = v;
    cap_pc       = pc;
    cap_instr    = instr;
    cap_result   = pc ^ 32'h5A5A_0000;
    cap_rd       = pc[6:2];
    cap_regwrite = rw;
  endtask

  task automatic reset_all();
    set_cap(1'b0, 32'h0, ADD, 1'b1);
    arm = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[9];

  initial begin
    n_vec = 0; n_fail = 0;
    tbl[0] = '{1, 1, 32'h99, ADD, 1, 0};  // capture in the arm cycle is dropped
    tbl[1] = '{0, 1, 32'd0,  ADD, 1, 1};
    tbl[2] = '{0, 1, 32'd4,  ADD, 1, 2};
    tbl[3] = '{0, 1, 32'd8,  ADD, 1, 3};
    tbl[4] = '{0, 1, 32'd12, BEQ, 2, 4};
    tbl[5] = '{0, 1, 32'd16, ADD, 2, 5};
    tbl[6] = '{0, 1, 32'd20, ADD, 3, 6};
    tbl[7] = '{0, 1, 32'd24, BEQ, 3, 6};  // ignored in DONE
    tbl[8] = '{1, 0, 32'd28, ADD, 3, 6};  // arm ignored in DONE

    reset_all();
    compare();
    chk("reset_state", state, 0);
    chk("reset_count", count, 0);

    // Basic trigger, table driven
    trig_opcode = 6'b000100; trig_mask = 6'b111111; post_cnt = 3'd2;
    foreach (tbl[i]) begin
      arm = tbl[i].arm;
      set_cap(tbl[i].valid, tbl[i].pc, tbl[i].instr, 1'b1);
      tick();
      chk("tbl_state", state, tbl[i].exp_state);
      chk("tbl_count", count, tbl[i].exp_count);
    end
    arm = 1'b0; set_cap(1'b0, 32'h0, ADD, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("basic_rd_pc", out_pc, 4 * i);
      tick();
    end
    chk("basic_idle", state, 0);
    out_ready = 1'b0;

    // Wrap with overflow, then backpressure in DONE
    post_cnt = 3'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_cap(1'b1, 4 * i, ADD, 1'b1);
      tick();
    end
    set_cap(1'b1, 32'd48, BEQ, 1'b1);
    tick();
    set_cap(1'b0, 32'h0, ADD, 1'b1);
    chk("wrap_count", count, 8);
    chk("wrap_ovf", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_pc", out_pc, 20);
      chk("bp_count", count, 8);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("wrap_rd_pc", out_pc, 20 + 4 * i);
      tick();
    end
    out_ready = 1'b0;

    // Zero mask: first qualifying capture triggers
    trig_mask = 6'b000000;
    arm = 1'b1; tick(); arm = 1'b0;
    set_cap(1'b1, 32'd100, ADD, 1'b1);
    tick();
    set_cap(1'b0, 32'h0, ADD, 1'b1);
    chk("mask0_state", state, 3);
    chk("mask0_count", count, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("mask0_idle", state, 0);

    // Asynchronous reset in POST
    trig_mask = 6'b111111; post_cnt = 3'd3;
    arm = 1'b1; tick(); arm = 1'b0;
    set_cap(1'b1, 32'd0, BEQ, 1'b1); tick();
    set_cap(1'b1, 32'd4, ADD, 1'b1); tick();
    set_cap(1'b0, 32'h0, ADD, 1'b1);
    chk("pre_rst_post", state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    model_reset();
    #2 rst_n = 1'b1;
    tick();

    // Register-write filter on the second instance
    reset_all();
    trig_opcode = 6'b001001; trig_mask = 6'b111111; post_cnt = 3'd1;
    arm = 1'b1; tick(); arm = 1'b0;
    set_cap(1'b1, 32'd0, ADDIU, 1'b1); tick();
    set_cap(1'b1, 32'd4, SW, 1'b0);    tick();
    set_cap(1'b1, 32'd8, ADDIU, 1'b1); tick();
    set_cap(1'b0, 32'h0, ADD, 1'b1);
    chk("filt_state", f_state, 3);
    chk("filt_count", f_count, 2);
    chk("filt_pc0", f_out_pc, 0);
    out_ready = 1'b1; tick();
    chk("filt_pc1", f_out_pc, 8);
    tick();
    chk("filt_idle", f_state, 0);
    out_ready = 1'b0;

    // Random traffic against the model
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] ops[4];
      ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h09; ops[3] = 6'h2b;
      arm          = ($urandom % 24) == 0;
      cap_valid    = $urandom % 2;
      cap_pc       = $urandom & 32'hFFFF_FFFC;
      cap_instr    = {ops[$urandom % 4], 26'($urandom)};
      cap_result   = $urandom;
      cap_rd       = 5'($urandom);
      cap_regwrite = $urandom % 2;
      trig_opcode  = ops[$urandom % 4];
      trig_mask    = (($urandom % 4) == 0) ? 6'($urandom) : 6'b111111;
      post_cnt     = 3'($urandom);
      out_ready    = ($urandom % 3) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
